add32_seq: RTL and testbench

ADD32_SEQ -- requirements
Module: add32_seq

---
 rtl/add32_pkg.sv | 13 +
 rtl/add1.sv | 13 +
 rtl/add16.sv | 28 ++
 rtl/add32_seq.sv | 107 ++++++++++
 tb/tb_add32_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/add32_pkg.sv
// Shared definitions for the multi-cycle 32-bit adder: FSM encoding and slice width.
package add32_pkg;

  localparam int unsigned SliceW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/add1.sv
// Single-bit full adder; the leaf cell of the ripple slice.
module add1 (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/add16.sv
// 16-bit ripple-carry slice built from add1 cells.
module add16
  import add32_pkg::*;
(
  input  logic [SliceW-1:0] a_i,
  input  logic [SliceW-1:0] b_i,
  input  logic              ci_i,
  output logic [SliceW-1:0] s_o,
  output logic              co_o
);

  logic [SliceW:0] carry;

  assign carry[0] = ci_i;

  for (genvar i = 0; i < SliceW; i++) begin : g_bit
    add1 u_add1 (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (carry[i]),
      .s_o  (s_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o = carry[SliceW];

endmodule

// File: rtl/add32_seq.sv
// Sequential 32-bit adder: one shared 16-bit slice used for the low half, then the high half,
// with a valid/ready handshake on both sides.
module add32_seq
  import add32_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  state_e state_q, state_d;

  logic [W-1:0] a_q, b_q, sum_q;
  logic         cin_q, carry_q, cout_q, ovf_q;
  logic         cap_en, lo_en, hi_en, hi_sel;

  logic [SliceW-1:0] add_a, add_b, add_s;
  logic              add_ci, add_co;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    lo_en   = 1'b0;
    hi_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cap_en  = 1'b1;
          state_d = StLo;
        end
      end
      StLo: begin
        lo_en   = 1'b1;
        state_d = StHi;
      end
      StHi: begin
        hi_en   = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Slice operands are steered by state; only HI sees the upper halves and the slice carry.
  assign hi_sel = (state_q == StHi);
  assign add_a  = hi_sel ? a_q[W-1:SliceW] : a_q[SliceW-1:0];
  assign add_b  = hi_sel ? b_q[W-1:SliceW] : b_q[SliceW-1:0];
  assign add_ci = hi_sel ? carry_q : cin_q;

  add16 u_add16 (
    .a_i  (add_a),
    .b_i  (add_b),
    .ci_i (add_ci),
    .s_o  (add_s),
    .co_o (add_co)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
      if (lo_en) begin
        sum_q[SliceW-1:0] <= add_s;
        carry_q           <= add_co;
      end
      if (hi_en) begin
        sum_q[W-1:SliceW] <= add_s;
        cout_q            <= add_co;
        ovf_q             <= (a_q[W-1] == b_q[W-1]) && (add_s[SliceW-1] != a_q[W-1]);
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: scoreboard of expected results, checked at out_valid.
module tb_add32_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add32_seq #(.W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    res_t        r;
    t      = {1'b0, x} + {1'b0, y} + {32'b0, c};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] x, input logic [31:0] y, input logic c);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    end
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    sb.push_back(model(x, y, c));
    step;
    // Scramble inputs so an in-flight result depending on them would be caught.
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int hold);
    int   cyc;
    res_t exp;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 10) begin
      step;
      cyc++;
      a = ~a;
    end
    n_vec++;
    if (cyc != 2) begin
      n_err++;
      $display("FAIL latency: cycles after accept=%0d want 2", cyc);
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: queue empty at result, want 1 entry");
      return;
    end
    exp = sb.pop_front();
    n_vec++;
    if ({sum, cout, ovf} !== exp) begin
      n_err++;
      $display("FAIL result: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, exp.sum, exp.cout, exp.ovf);
    end
    for (int i = 0; i < hold; i++) begin
      step;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== exp) begin
        n_err++;
        $display("FAIL hold: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 out_valid, in_ready, sum, cout, ovf, exp.sum, exp.cout, exp.ovf);
      end
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {sum, cout, ovf} !== exp) begin
      n_err++;
      $display("FAIL post_handshake: in_ready=%b out_valid=%b sum=%h want 1 0 %h",
               in_ready, out_valid, sum, exp.sum);
    end
  endtask

  task automatic test_reset;
    // Reset coinciding with in_valid must not capture.
    resetn   = 1'b0;
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    step;
    step;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    n_vec++;
    if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b want 0 0 0", sum, cout, ovf);
    end
    resetn   = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_no_capture: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_vectors;
    accept(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    collect(0);
    accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    collect(0);
    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    collect(0);
    accept(32'h8000_0000, 32'h8000_0000, 1'b0);
    collect(0);
    for (int i = 0; i < 6; i++) begin
      accept($urandom, $urandom, 1'($urandom_range(0, 1)));
      collect(0);
    end
  endtask

  task automatic test_backpressure;
    accept(32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    collect(5);
  endtask

  task automatic test_reset_abort;
    a        = 32'hCAFE_0000;
    b        = 32'h0000_F00D;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_hi: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    resetn = 1'b0;
    step;
    resetn = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 ||
        ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      step;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_valid: out_valid=%b want 0", out_valid);
      end
    end
    accept(32'h0000_0002, 32'h0000_0003, 1'b0);
    collect(0);
  endtask

  task automatic test_back_to_back;
    res_t exp;
    logic exp_ready;
    int   n_acc;
    int   n_res;
    n_acc     = 0;
    n_res     = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      exp_ready = (k % 4 == 0);
      n_vec++;
      if (in_ready !== exp_ready || out_valid !== (k % 4 == 3)) begin
        n_err++;
        $display("FAIL b2b_flags k=%0d: in_ready=%b out_valid=%b want %b %b",
                 k, in_ready, out_valid, exp_ready, (k % 4 == 3));
      end
      if (out_valid === 1'b1) begin
        n_res++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b_scoreboard: queue empty at result, want 1 entry");
        end else begin
          exp = sb.pop_front();
          if ({sum, cout, ovf} !== exp) begin
            n_err++;
            $display("FAIL b2b_result: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, exp.sum, exp.cout, exp.ovf);
          end
        end
      end
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      if (exp_ready) begin
        sb.push_back(model(a, b, cin));
        n_acc++;
      end
      step;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (n_res != n_acc || sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: results=%0d pending=%0d want %0d 0", n_res, sb.size(), n_acc);
    end
  endtask

  initial begin
    step;
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
